key_event_decoder: RTL and testbench

- Downstream stage of the serial keyboard scanner.
- Takes each 32-bit key snapshot the scanner assembles from the shift chain, debounces every key over several consecutive frames, and converts stable press/release transitions into 6-bit key events.
- Events are queued in a small FIFO and read by the host logic through a valid/ready interface.

---
 rtl/key_event_decoder_if.sv | 19 +
 rtl/key_event_decoder.sv | 147 ++++++++++++++
 tb/tb_key_event_decoder.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/key_event_decoder_if.sv
// Event handshake between the key event decoder and the host.
// The decoder drives valid/data; the host drives ready.
interface key_event_decoder_if;
    logic       EV_VALID;
    logic [5:0] EV_DATA;
    logic       EV_READY;

    modport master (
        output EV_VALID,
        output EV_DATA,
        input  EV_READY
    );

    modport slave (
        input  EV_VALID,
        input  EV_DATA,
        output EV_READY
    );
endinterface

// File: rtl/key_event_decoder.sv
// Debounces 32-key scanner snapshots and queues press/release events.
// Events leave a show-ahead FIFO in ascending key order per frame.
module key_event_decoder #(
    parameter int DEB_FRAMES = 3,
    parameter int FIFO_DEPTH = 8,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                       CLK,
    input  logic                       RSTN,
    input  logic                       LOAD,
    input  logic [31:0]                BAR,
    input  logic                       OVF_CLR,
    output logic [31:0]                KEYS,
    output logic                       OVF,
    output logic                       MISS,
    key_event_decoder_if.master        ev
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [3:0] DEB_MAX = 4'(DEB_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE,
        UPDATE,
        SCAN
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        load_d;
    logic        frame_done;
    logic [31:0] raw_in;
    logic [31:0] raw;
    logic [31:0] keys;
    logic [31:0] pend;
    logic [3:0]  cnt [32];
    logic [4:0]  idx;

    logic [5:0]  mem [FIFO_DEPTH];
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic        empty;
    logic        full;
    logic        push;
    logic        pop;
    logic        push_ok;
    logic [5:0]  push_data;

    assign frame_done = load_d & ~LOAD;
    assign raw_in     = (ACTIVE_LOW != 0) ? ~BAR : BAR;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (frame_done) state_nxt = UPDATE;
            UPDATE:  state_nxt = SCAN;
            SCAN:    if (idx == 5'd31) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Debounce and scan datapath; pend is cleared whether or not the push lands
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            load_d <= 1'b0;
            raw    <= '0;
            keys   <= '0;
            pend   <= '0;
            idx    <= '0;
            for (int k = 0; k < 32; k++) cnt[k] <= '0;
        end else begin
            load_d <= LOAD;
            unique case (state)
                IDLE: begin
                    if (frame_done) raw <= raw_in;
                end
                UPDATE: begin
                    for (int k = 0; k < 32; k++) begin
                        if (raw[k] == keys[k]) begin
                            cnt[k] <= '0;
                        end else if (cnt[k] == DEB_MAX) begin
                            keys[k] <= ~keys[k];
                            cnt[k]  <= '0;
                            pend[k] <= 1'b1;
                        end else begin
                            cnt[k] <= cnt[k] + 4'd1;
                        end
                    end
                    idx <= '0;
                end
                SCAN: begin
                    pend[idx] <= 1'b0;
                    idx       <= idx + 5'd1;
                end
                default: ;
            endcase
        end
    end

    assign push      = (state == SCAN) && pend[idx];
    assign push_data = {keys[idx], idx};

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) &&
                     (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop     = ev.EV_VALID & ev.EV_READY;
    assign push_ok = push & (~full | pop);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop)     rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (push_ok) mem[wptr[AW-1:0]] <= push_data;
    end

    // Setting a flag takes priority over a same-cycle clear
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            OVF  <= 1'b0;
            MISS <= 1'b0;
        end else begin
            if (push & full & ~pop) OVF <= 1'b1;
            else if (OVF_CLR)       OVF <= 1'b0;
            if (frame_done && state != IDLE) MISS <= 1'b1;
            else if (OVF_CLR)                MISS <= 1'b0;
        end
    end

    assign ev.EV_VALID = ~empty;
    assign ev.EV_DATA  = empty ? 6'd0 : mem[rptr[AW-1:0]];
    assign KEYS        = keys;
endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder with a queue-based scoreboard.
// The monitor pops expected events on every accepted handshake.
module tb_key_event_decoder;
    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic        LOAD = 1'b0;
    logic [31:0] BAR = 32'hFFFF_FFFF;
    logic        OVF_CLR = 1'b0;
    logic [31:0] KEYS;
    logic        OVF;
    logic        MISS;

    int checks = 0;
    int errors = 0;
    logic [5:0] exp_q [$];

    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    key_event_decoder_if evi ();

    key_event_decoder dut (
        .CLK     (CLK),
        .RSTN    (RSTN),
        .LOAD    (LOAD),
        .BAR     (BAR),
        .OVF_CLR (OVF_CLR),
        .KEYS    (KEYS),
        .OVF     (OVF),
        .MISS    (MISS),
        .ev      (evi.master)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (RSTN && evi.EV_VALID === 1'b1 && evi.EV_READY === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got %h expected none",
                         evi.EV_DATA);
            end else begin
                logic [5:0] e;
                e = exp_q.pop_front();
                if (evi.EV_DATA !== e) begin
                    errors++;
                    $display("FAIL event: got %h expected %h",
                             evi.EV_DATA, e);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic frame(input logic [31:0] bar, input int rdy_at = -1);
        cyc(1);
        LOAD = 1'b1;
        BAR  = bar;
        cyc(3);
        LOAD = 1'b0;
        if (rdy_at >= 0) begin
            cyc(rdy_at);
            evi.EV_READY = 1'b1;
        end
        cyc(45);
    endtask

    task automatic pulse_clr();
        OVF_CLR = 1'b1;
        cyc(1);
        OVF_CLR = 1'b0;
        cyc(1);
    endtask

    initial begin
        evi.EV_READY = 1'b1;
        cyc(3);
        chk("rst_valid", 32'(evi.EV_VALID), 0);
        chk("rst_data", 32'(evi.EV_DATA), 0);
        chk("rst_keys", KEYS, 0);
        chk("rst_ovf", 32'(OVF), 0);
        chk("rst_miss", 32'(MISS), 0);
        RSTN = 1'b1;
        cyc(2);
        repeat (3) frame(ONES);
        chk("idle_keys", KEYS, 0);

        // single key 5 press and release
        frame(~32'h20);
        frame(~32'h20);
        chk("k5_two_frames", KEYS, 0);
        exp_q.push_back(6'h25);
        frame(~32'h20);
        chk("k5_pressed", KEYS, 32'h20);
        repeat (2) frame(ONES);
        exp_q.push_back(6'h05);
        frame(ONES);
        chk("k5_released", KEYS, 0);

        // bounce: 2 low, 1 high, 2 low
        frame(~32'h20);
        frame(~32'h20);
        frame(ONES);
        frame(~32'h20);
        frame(~32'h20);
        chk("bounce_keys", KEYS, 0);
        frame(ONES);

        // keys 3 and 17 together
        repeat (2) frame(~32'h0002_0008);
        exp_q.push_back(6'h23);
        exp_q.push_back(6'h31);
        frame(~32'h0002_0008);
        chk("k3_17_pressed", KEYS, 32'h0002_0008);
        repeat (2) frame(ONES);
        exp_q.push_back(6'h03);
        exp_q.push_back(6'h11);
        frame(ONES);
        chk("k3_17_released", KEYS, 0);

        // overflow: 9 presses with ready low
        evi.EV_READY = 1'b0;
        repeat (2) frame(~32'h1FF);
        for (int i = 0; i < 8; i++) exp_q.push_back(6'(6'h20 + i));
        frame(~32'h1FF);
        chk("ovf_set", 32'(OVF), 1);
        chk("ovf_keys", KEYS, 32'h1FF);
        chk("ovf_valid", 32'(evi.EV_VALID), 1);
        chk("ovf_head", 32'(evi.EV_DATA), 32'h20);
        pulse_clr();
        chk("ovf_clr", 32'(OVF), 0);
        evi.EV_READY = 1'b1;
        cyc(20);
        chk("ovf_drained", 32'(evi.EV_VALID), 0);

        // full FIFO with ready rising during the 9th push
        evi.EV_READY = 1'b0;
        repeat (2) frame(ONES);
        for (int i = 0; i < 9; i++) exp_q.push_back(6'(i));
        frame(ONES, 10);
        chk("full_pop_ovf", 32'(OVF), 0);
        chk("full_pop_keys", KEYS, 0);

        // second falling edge 10 cycles after the first
        cyc(1);
        LOAD = 1'b1;
        BAR  = ONES;
        cyc(3);
        LOAD = 1'b0;
        cyc(5);
        LOAD = 1'b1;
        BAR  = ~32'h200;
        cyc(5);
        LOAD = 1'b0;
        cyc(45);
        chk("miss_set", 32'(MISS), 1);
        pulse_clr();
        chk("miss_clr", 32'(MISS), 0);
        repeat (2) frame(~32'h200);
        chk("miss_no_effect", KEYS, 0);
        exp_q.push_back(6'h29);
        frame(~32'h200);
        chk("k9_pressed", KEYS, 32'h200);
        repeat (2) frame(ONES);
        exp_q.push_back(6'h09);
        frame(ONES);

        // reset during SCAN with pending events
        evi.EV_READY = 1'b0;
        repeat (2) frame(~32'h0C00);
        cyc(1);
        LOAD = 1'b1;
        BAR  = ~32'h0C00;
        cyc(3);
        LOAD = 1'b0;
        cyc(4);
        RSTN = 1'b0;
        cyc(1);
        chk("midrst_valid", 32'(evi.EV_VALID), 0);
        chk("midrst_data", 32'(evi.EV_DATA), 0);
        chk("midrst_keys", KEYS, 0);
        chk("midrst_flags", {30'd0, OVF, MISS}, 0);
        BAR = ONES;
        cyc(2);
        RSTN = 1'b1;
        evi.EV_READY = 1'b1;
        repeat (3) frame(ONES);
        chk("postrst_keys", KEYS, 0);
        chk("postrst_valid", 32'(evi.EV_VALID), 0);

        cyc(20);
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
